serial_decrypt_receiver: RTL

SERIAL_DECRYPT_RECEIVER -- requirements
Module: serial_decrypt_receiver

---
 rtl/serial_decrypt_receiver_pkg.sv | 16 +
 rtl/rx_decrypt_core.sv | 27 ++
 rtl/serial_decrypt_receiver.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_decrypt_receiver_pkg.sv
// Shared types and framing constants for the serial decrypt receiver and its
// decrypt core.
package serial_decrypt_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_t;

    localparam int         FRAME_DATA_BITS = 8;
    localparam logic       START_BIT       = 1'b1;
    localparam logic       STOP_BIT        = 1'b0;
    localparam logic [7:0] DEFAULT_KEY     = 8'd43;

endpackage

// File: rtl/rx_decrypt_core.sv
// Combinational byte decrypt: XOR with the key, invert the even bits and
// rotate the odd bits (1<-5, 3<-1, 5<-3, 7 stays).
module rx_decrypt_core
    import serial_decrypt_receiver_pkg::*;
(
    input  logic [FRAME_DATA_BITS-1:0] cipher,
    input  logic [FRAME_DATA_BITS-1:0] key,
    output logic [FRAME_DATA_BITS-1:0] plain
);

    logic [FRAME_DATA_BITS-1:0] mixed;

    assign mixed = cipher ^ key;

    genvar gi;
    generate
        for (gi = 0; gi < FRAME_DATA_BITS / 2; gi++) begin : g_even_bits
            assign plain[2*gi] = ~mixed[2*gi];
        end
    endgenerate

    assign plain[1] = mixed[5];
    assign plain[3] = mixed[1];
    assign plain[5] = mixed[3];
    assign plain[7] = mixed[7];

endmodule

// File: rtl/serial_decrypt_receiver.sv
// Serial frame receiver feeding a first-word-fall-through output FIFO.
// Define RX_DECRYPT_EN to store decrypted bytes; otherwise raw cipher bytes are stored.
module serial_decrypt_receiver
    import serial_decrypt_receiver_pkg::*;
#(
    parameter logic [7:0] KEY        = DEFAULT_KEY,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       serial_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       framing_error,
    output logic       overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(FRAME_DATA_BITS);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_DATA_BITS - 1);

    rx_state_t                  state_reg, state_next;
    logic [BIT_W-1:0]           bit_cnt_reg, bit_cnt_next;
    logic [FRAME_DATA_BITS-1:0] cipher_reg, cipher_next;
    logic                       push_req;
    logic                       frame_bad;
    logic [FRAME_DATA_BITS-1:0] push_byte;

    logic [FRAME_DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]           rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]           count_reg, count_next, remaining;
    logic [FRAME_DATA_BITS-1:0] head_reg, head_next;
    logic                       overflow_reg, overflow_next;
    logic                       full, pop, push_ok;

`ifdef RX_DECRYPT_EN
    rx_decrypt_core u_decrypt (
        .cipher (cipher_reg),
        .key    (KEY),
        .plain  (push_byte)
    );
`else
    logic [7:0] unused_key;
    assign unused_key = KEY;
    assign push_byte  = cipher_reg;
`endif

    // Frame FSM: the completed cipher byte is only judged in STOP.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        cipher_next  = cipher_reg;
        push_req     = 1'b0;
        frame_bad    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (serial_in == START_BIT) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                cipher_next  = {serial_in, cipher_reg[FRAME_DATA_BITS-1:1]};
                bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                if (bit_cnt_reg == LAST_BIT) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                state_next = IDLE;
                if (serial_in == STOP_BIT) begin
                    push_req = 1'b1;
                end else begin
                    frame_bad = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    always_comb begin
        full          = (count_reg == FULL_COUNT);
        pop           = out_valid & out_ready;
        push_ok       = push_req & (~full | pop);
        overflow_next = overflow_reg | (push_req & full & ~pop);
        remaining     = count_reg - CNT_W'(pop);
        count_next    = remaining + CNT_W'(push_ok);
        rd_ptr_next   = rd_ptr_reg + PTR_W'(pop);
        wr_ptr_next   = wr_ptr_reg + PTR_W'(push_ok);
        head_next     = '0;
        if (count_next != '0) begin
            head_next = (remaining == '0) ? push_byte : fifo_mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            cipher_reg   <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            cipher_reg   <= cipher_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            head_reg     <= head_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage carries no reset so it can map onto RAM resources.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= push_byte;
        end
    end

    assign out_data      = head_reg;
    assign out_valid     = (count_reg != '0);
    assign overflow      = overflow_reg;
    assign framing_error = frame_bad & reset_n;

endmodule
